// File: rtl/crc8_frame_ctrl.sv
// ---------------------------------------------------------------------------
// crc8_frame_ctrl
//
// Feeds a byte stream into a shared byte-serial CRC-8 engine, one byte per
// engine transaction. It clears the engine at frame start, issues a one-cycle
// enable per byte and waits for the completion pulse. When the final byte of
// a frame completes, it publishes the frame CRC, a residue check and the
// frame length. If the engine never completes a byte, it reports a timeout
// error instead.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     input byte handshake
//   s_data, s_last      input byte and end-of-frame marker
//   abort               drop the current frame or result and return to IDLE
//   crc_in              byte presented to the engine, held until next accept
//   crc_en, crc_clr     one-cycle engine start and clear pulses
//   crc_out, crc_done   engine CRC register and byte-complete pulse
//   res_valid/res_ready result handshake
//   res_crc, res_ok     frame CRC (0x00 on error) and zero-residue flag
//   res_err             engine timeout
//   res_len             bytes accepted in the frame, saturating at 255
// ---------------------------------------------------------------------------
module crc8_frame_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       abort,
    output logic [7:0] crc_in,
    output logic       crc_en,
    output logic       crc_clr,
    input  logic [7:0] crc_out,
    input  logic       crc_done,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_crc,
    output logic       res_ok,
    output logic       res_err,
    output logic [7:0] res_len
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        EN,
        WAIT,
        RESULT,
        ERR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       first;
    logic       last_q;
    logic [7:0] len_cnt;
    logic [7:0] timer;
    logic       timeout_hit;

    // The timer holds the number of completed WAIT cycles minus one, so the
    // edge that ends the TIMEOUT-th WAIT cycle sees timer == TIMEOUT-1.
    // A done pulse on that same cycle takes precedence over the timeout.
    assign timeout_hit = (state == WAIT) && !crc_done &&
                         (timer == 8'(TIMEOUT - 1));

    // Engine strobes and the input ready are pure state decodes so that no
    // input can reach them combinationally.
    assign s_ready   = (state == IDLE);
    assign crc_clr   = (state == CLR);
    assign crc_en    = (state == EN);
    assign res_valid = (state == RESULT) || (state == ERR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nxt = first ? CLR : EN;
                end
            end
            CLR:  state_nxt = EN;
            EN:   state_nxt = WAIT;
            WAIT: begin
                if (crc_done) begin
                    state_nxt = last_q ? RESULT : IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            RESULT, ERR: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Datapath: byte capture, length count, WAIT timer and result latches.
    // An abort discards any pending result and re-arms the frame-start clear;
    // it also blocks byte capture so nothing is issued to the engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first   <= 1'b1;
            last_q  <= 1'b0;
            crc_in  <= 8'h00;
            len_cnt <= 8'h00;
            timer   <= 8'h00;
            res_crc <= 8'h00;
            res_ok  <= 1'b0;
            res_err <= 1'b0;
            res_len <= 8'h00;
        end else if (abort) begin
            first   <= 1'b1;
            res_ok  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        crc_in <= s_data;
                        last_q <= s_last;
                        if (first) begin
                            len_cnt <= 8'd1;
                        end else if (len_cnt != 8'hFF) begin
                            len_cnt <= len_cnt + 8'd1;
                        end
                    end
                end
                CLR: begin
                    first <= 1'b0;
                end
                EN: begin
                    timer <= 8'h00;
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (crc_done && last_q) begin
                        res_crc <= crc_out;
                        res_ok  <= (crc_out == 8'h00);
                        res_len <= len_cnt;
                    end else if (timeout_hit) begin
                        res_err <= 1'b1;
                        res_crc <= 8'h00;
                        res_ok  <= 1'b0;
                        res_len <= len_cnt;
                    end
                end
                RESULT, ERR: begin
                    if (res_ready) begin
                        first   <= 1'b1;
                        res_ok  <= 1'b0;
                        res_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crc8_frame_ctrl
//
// Directed bench for crc8_frame_ctrl. A behavioural CRC-8 engine (poly 0x07,
// init 0x00) answers each crc_en with a done pulse after a programmable
// delay, or never when muted. Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_crc8_frame_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       abort;
    logic [7:0] crc_in;
    logic       crc_en;
    logic       crc_clr;
    logic [7:0] crc_out;
    logic       crc_done;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_crc;
    logic       res_ok;
    logic       res_err;
    logic [7:0] res_len;

    int checks   = 0;
    int failures = 0;

    // Engine model state
    logic [7:0] eng_crc  = 8'h00;
    logic [7:0] eng_byte = 8'h00;
    logic       eng_done = 1'b0;
    int         eng_cnt  = 0;
    int         engine_delay = 9;
    bit         engine_mute  = 1'b0;

    // Strobe monitors
    int clr_count = 0;
    int en_count  = 0;

    localparam logic [7:0] CHECK_STR [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                             8'h36, 8'h37, 8'h38, 8'h39};

    always #5 clk = ~clk;

    crc8_frame_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .abort     (abort),
        .crc_in    (crc_in),
        .crc_en    (crc_en),
        .crc_clr   (crc_clr),
        .crc_out   (crc_out),
        .crc_done  (crc_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_ok    (res_ok),
        .res_err   (res_err),
        .res_len   (res_len)
    );

    assign crc_out  = eng_crc;
    assign crc_done = eng_done;

    function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Behavioural engine: clear wins, en loads a countdown, done fires once
    // the countdown expires unless the engine is muted.
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (crc_clr) begin
            eng_crc <= 8'h00;
            eng_cnt <= 0;
        end else if (crc_en) begin
            eng_byte <= crc_in;
            eng_cnt  <= engine_delay;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !engine_mute) begin
                eng_crc  <= crc8Step(eng_crc, eng_byte);
                eng_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (crc_clr) clr_count <= clr_count + 1;
        if (crc_en)  en_count  <= en_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte at a negedge once s_ready is seen, hold it one cycle
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitResult();
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("result_wait", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic releaseResult();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // Cycles spent in WAIT before res_valid, measured from the EN cycle
    task automatic measureWait(output int cycles);
        int n;
        int k;
        n = 0;
        while (crc_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        while (res_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        cycles = k - 1;
    endtask

    initial begin
        int clr_base;
        int en_base;
        int cyc;
        bit ready_seen;
        bit valid_drop;
        bit out_change;

        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_crc_in",    {24'd0, crc_in},  32'd0);
        checkOutput("rst_crc_en",    {31'd0, crc_en},  32'd0);
        checkOutput("rst_crc_clr",   {31'd0, crc_clr}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_res_crc",   {24'd0, res_crc}, 32'd0);
        checkOutput("rst_res_flags", {30'd0, res_ok, res_err}, 32'd0);
        checkOutput("rst_res_len",   {24'd0, res_len}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_s_ready", {31'd0, s_ready}, 32'd1);

        // Frame "123456789" -> 0xF4
        clr_base = clr_count;
        en_base  = en_count;
        for (int i = 0; i < 9; i++) applyStimulus(CHECK_STR[i], i == 8);
        waitResult();
        checkOutput("f1_crc", {24'd0, res_crc}, 32'hF4);
        checkOutput("f1_ok",  {31'd0, res_ok},  32'd0);
        checkOutput("f1_err", {31'd0, res_err}, 32'd0);
        checkOutput("f1_len", {24'd0, res_len}, 32'd9);
        checkOutput("f1_clr_pulses", clr_count - clr_base, 32'd1);
        checkOutput("f1_en_pulses",  en_count - en_base,   32'd9);
        releaseResult();

        // Frame carrying its own CRC -> zero residue
        for (int i = 0; i < 9; i++) applyStimulus(CHECK_STR[i], 1'b0);
        applyStimulus(8'hF4, 1'b1);
        waitResult();
        checkOutput("f2_crc", {24'd0, res_crc}, 32'h00);
        checkOutput("f2_ok",  {31'd0, res_ok},  32'd1);
        checkOutput("f2_len", {24'd0, res_len}, 32'd10);

        // Hold the result for 20 cycles while a byte is offered
        en_base    = en_count;
        ready_seen = 1'b0;
        valid_drop = 1'b0;
        out_change = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (s_ready !== 1'b0) ready_seen = 1'b1;
            if (res_valid !== 1'b1) valid_drop = 1'b1;
            if (res_crc !== 8'h00 || res_ok !== 1'b1 || res_len !== 8'd10) out_change = 1'b1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("hold_s_ready_low", {31'd0, ready_seen}, 32'd0);
        checkOutput("hold_valid_kept",  {31'd0, valid_drop}, 32'd0);
        checkOutput("hold_outputs",     {31'd0, out_change}, 32'd0);
        checkOutput("hold_no_en",       en_count - en_base,  32'd0);
        checkOutput("hold_crc_in",      {24'd0, crc_in},     32'hF4);
        releaseResult();
        checkOutput("release_idle", {31'd0, s_ready}, 32'd1);
        checkOutput("release_valid", {31'd0, res_valid}, 32'd0);

        clr_base = clr_count;
        applyStimulus(8'h00, 1'b1);
        waitResult();
        checkOutput("f3_clr_pulses", clr_count - clr_base, 32'd1);
        checkOutput("f3_crc", {24'd0, res_crc}, 32'h00);
        checkOutput("f3_len", {24'd0, res_len}, 32'd1);
        releaseResult();

        // Engine never answers -> timeout after exactly TIMEOUT WAIT cycles
        engine_mute = 1'b1;
        applyStimulus(8'hAB, 1'b1);
        measureWait(cyc);
        checkOutput("to_cycles", cyc, TIMEOUT);
        checkOutput("to_valid",  {31'd0, res_valid}, 32'd1);
        checkOutput("to_err",    {31'd0, res_err},   32'd1);
        checkOutput("to_crc",    {24'd0, res_crc},   32'h00);
        checkOutput("to_ok",     {31'd0, res_ok},    32'd0);
        releaseResult();
        checkOutput("to_err_clear", {31'd0, res_err}, 32'd0);
        engine_mute = 1'b0;

        // Done on WAIT cycle 16 beats the coincident timeout
        engine_delay = 15;
        applyStimulus(8'h31, 1'b1);
        measureWait(cyc);
        checkOutput("d16_cycles", cyc, TIMEOUT);
        checkOutput("d16_err", {31'd0, res_err}, 32'd0);
        checkOutput("d16_crc", {24'd0, res_crc}, 32'h97);
        checkOutput("d16_len", {24'd0, res_len}, 32'd1);
        releaseResult();
        engine_delay = 9;

        // Abort during WAIT of byte 3
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        en_base = en_count;
        checkOutput("abort_idle",  {31'd0, s_ready},   32'd1);
        checkOutput("abort_valid", {31'd0, res_valid}, 32'd0);
        valid_drop = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b0) valid_drop = 1'b1;
        end
        checkOutput("abort_no_result", {31'd0, valid_drop}, 32'd0);
        checkOutput("abort_no_en", en_count - en_base, 32'd0);
        clr_base = clr_count;
        applyStimulus(8'h00, 1'b1);
        waitResult();
        checkOutput("ab_clr_pulses", clr_count - clr_base, 32'd1);
        checkOutput("ab_crc", {24'd0, res_crc}, 32'h00);
        checkOutput("ab_len", {24'd0, res_len}, 32'd1);
        checkOutput("ab_ok",  {31'd0, res_ok},  32'd1);
        releaseResult();

        // Reset pulsed mid-WAIT clears outputs without a clock edge
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_crc_in",    {24'd0, crc_in},  32'd0);
        checkOutput("arst_strobes",   {30'd0, crc_en, crc_clr}, 32'd0);
        checkOutput("arst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("arst_res_crc",   {24'd0, res_crc}, 32'd0);
        checkOutput("arst_res_flags", {30'd0, res_ok, res_err}, 32'd0);
        checkOutput("arst_res_len",   {24'd0, res_len}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 9; i++) applyStimulus(CHECK_STR[i], i == 8);
        waitResult();
        checkOutput("f4_crc", {24'd0, res_crc}, 32'hF4);
        checkOutput("f4_len", {24'd0, res_len}, 32'd9);
        checkOutput("f4_err", {31'd0, res_err}, 32'd0);
        releaseResult();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc8_frame_ctrl.md
# crc8_frame_ctrl

Sequencer that feeds a byte stream into the shared byte-serial CRC-8 engine, one byte per engine transaction, and reports the frame CRC. It accepts bytes on a valid/ready stream, clears the engine at frame start, and issues a one-cycle enable per byte. It holds each byte stable until the engine's completion pulse, then publishes the result with a pass/fail check and a timeout error. It sits between the link receive/transmit framer and the CRC engine.

## Interface
- TIMEOUT, 16: cycles allowed in WAIT for crc_done before the error path is taken; legal range 10..255.
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_last  in  1  byte is final of frame (qualified by s_valid)
- s_ready  out  1  controller accepts byte this cycle
- abort  in  1  drop current frame/result, return to IDLE
- crc_in  out  8  byte presented to engine (registered)
- crc_en  out  1  one-cycle engine start pulse
- crc_clr  out  1  one-cycle engine clear pulse
- crc_out  in  8  engine CRC register
- crc_done  in  1  engine byte-complete pulse
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_crc  out  8  frame CRC (0x00 on error)
- res_ok  out  1  res_crc == 0x00 (residue check for frames that carry their CRC)
- res_err  out  1  engine timeout
- res_len  out  8  bytes accepted in frame, saturating at 255

## Operation
- States: IDLE, CLR, EN, WAIT, RESULT, ERR. The state register and an internal `first` flag reset to IDLE and 1.
- IDLE: s_ready=1. On s_valid: capture s_data into crc_in and s_last into `last_q`, then increment the length counter (saturating). If `first`=1, clear the length counter to 1 and go to CLR; otherwise go to EN.
- CLR: crc_clr=1 for exactly one cycle; set `first`=0; go to EN.
- EN: crc_en=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT: the timer increments each cycle.
  - crc_done=1 and last_q=0: go to IDLE.
  - crc_done=1 and last_q=1: latch res_crc=crc_out, res_ok=(crc_out==0x00), res_len; go to RESULT.
  - Timer reaches TIMEOUT with no done: res_err=1, res_crc=0x00, res_ok=0; go to ERR.
  - If done and timeout coincide, done wins.
- RESULT/ERR: res_valid=1, s_ready=0. On res_ready: go to IDLE, set `first`=1, clear res_valid/res_err/res_ok.
- crc_done outside WAIT is ignored.
- abort (any state, highest priority): next cycle the state is IDLE, `first`=1, res_valid/res_err/res_ok=0, and no crc_en/crc_clr is issued. Any pending result is discarded.
- crc_en, crc_clr, and s_ready decode from the state register only (no combinational path from inputs).

## Timing
- Reset values: s_ready=1 once rst_n deasserts (0 while in reset is not required; output is a state decode, IDLE gives 1). All other outputs 0: crc_in, crc_en, crc_clr, res_valid, res_crc, res_ok, res_err, res_len.
- Asserting rst_n low mid-frame immediately forces all of the above; the engine is re-cleared by the next frame's CLR.
- First byte accepted at edge t: crc_clr high t..t+1, crc_en high t+1..t+2, WAIT from t+2.
- Later bytes: crc_en high t..t+1.
- res_valid rises on the edge after the final crc_done.
- crc_in is stable from the accept edge until the next accept.
- Throughput is one byte per (engine latency + 2) cycles; s_ready is low throughout CLR/EN/WAIT.
- The timer counts in WAIT only. ERR is entered on the edge at which WAIT has lasted TIMEOUT cycles.

## Test plan
- The bench engine model is CRC-8, poly 0x07, init 0x00, with done 9 cycles after en. Frame "123456789" (0x31..0x39, s_last on 0x39) -> res_crc=0xF4, res_ok=0, res_len=9, res_err=0; exactly one crc_clr and 9 crc_en pulses.
- Same nine bytes followed by 0xF4 with s_last -> res_crc=0x00, res_ok=1, res_len=10.
- Hold res_ready low for 20 cycles after res_valid -> outputs stable, s_ready=0, a byte offered with s_valid is not accepted. Then res_ready=1 for one cycle -> IDLE, and the next byte produces a crc_clr.
- Engine model never pulses done -> res_valid=1, res_err=1, res_crc=0x00 exactly TIMEOUT=16 cycles after entering WAIT. Done arriving on cycle 16 -> normal result, no error.
- abort asserted during WAIT of byte 3 -> IDLE next cycle, res_valid stays 0. A following 1-byte frame 0x00 gets a fresh crc_clr, giving res_crc=0x00, res_len=1.
- rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously. After release, frame "123456789" again gives 0xF4.
